// File: rtl/rom_stream_reader_if.sv
//------------------------------------------------------------------------------
// rom_stream_reader_if : valid/ready byte stream with last-beat flag
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rom_stream_reader_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/rom_stream_reader.sv
//------------------------------------------------------------------------------
// rom_stream_reader : walks a block of a combinational ROM and streams the bytes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rom_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start_i,
  input  wire logic [ADDR_W-1:0] base_addr_i,
  input  wire logic [LEN_W-1:0]  length_i,
  input  wire logic              abort_i,
  output logic      [ADDR_W-1:0] rom_addr_o,
  input  wire logic [DATA_W-1:0] rom_data_i,
  rom_stream_reader_if.master    out_if,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            rom_addr_d  = base_addr_i;
            remaining_d = length_i;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      READ: begin
        if (abort_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (!valid_q || out_if.ready) begin
          // Acceptance of the held beat and capture of the next share one edge.
          data_d      = rom_data_i;
          valid_d     = 1'b1;
          last_d      = (remaining_q == LEN_W'(1));
          rom_addr_d  = rom_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (abort_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (valid_q && out_if.ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rom_addr_o   = rom_addr_q;
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign out_if.last  = last_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
//------------------------------------------------------------------------------
// tb_rom_stream_reader : directed checks of rom_stream_reader against a +0x10 ROM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic       abort = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  rom_stream_reader_if #(.DATA_W(8)) s_if ();

  rom_stream_reader #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .length_i    (length),
    .abort_i     (abort),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .out_if      (s_if),
    .busy_o      (busy),
    .done_o      (done)
  );

  assign rom_data = rom_addr + 8'h10;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    logic [7:0] first_data;
    logic [7:0] last_data;
  } xfer_t;

  typedef struct {
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [7:0] addr;
    logic       done;
  } stall_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transfer with ready held high; optionally keeps a competing start asserted.
  task automatic run_xfer(input xfer_t x, input bit spam_start);
    s_if.ready = 1'b1;
    base_addr  = x.base;
    length     = x.len;
    start      = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_addr", rom_addr, x.base);
    if (spam_start) begin
      base_addr = 8'h40;
      length    = 9'd5;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i < int'(x.len); i++) begin
      logic [7:0] exp_d;
      exp_d = x.first_data + 8'(i);
      tick();
      chk("beat_valid", s_if.valid, 1);
      chk("beat_data", s_if.data, exp_d);
      chk("beat_last", s_if.last, (i == int'(x.len) - 1));
      chk("beat_nodone", done, 0);
    end
    start = 1'b0;
    chk("final_data", s_if.data, x.last_data);
    tick();
    chk("done_pulse", done, 1);
    chk("done_novalid", s_if.valid, 0);
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", s_if.valid, 0);
  endtask

  xfer_t  xfers[5];
  stall_t stalls[7];

  initial begin
    xfers[0] = '{base: 8'h00, len: 9'd4,   first_data: 8'h10, last_data: 8'h13};
    xfers[1] = '{base: 8'hFE, len: 9'd4,   first_data: 8'h0E, last_data: 8'h11};
    xfers[2] = '{base: 8'hF0, len: 9'd1,   first_data: 8'h00, last_data: 8'h00};
    xfers[3] = '{base: 8'hFF, len: 9'd2,   first_data: 8'h0F, last_data: 8'h10};
    xfers[4] = '{base: 8'h80, len: 9'd256, first_data: 8'h90, last_data: 8'h8F};

    // Per-cycle view after the first beat of base=0x05, length=3.
    stalls[0] = '{ready: 1'b1, valid: 1'b1, data: 8'h16, last: 1'b0, addr: 8'h07, done: 1'b0};
    stalls[1] = '{ready: 1'b0, valid: 1'b1, data: 8'h16, last: 1'b0, addr: 8'h07, done: 1'b0};
    stalls[2] = '{ready: 1'b0, valid: 1'b1, data: 8'h16, last: 1'b0, addr: 8'h07, done: 1'b0};
    stalls[3] = '{ready: 1'b1, valid: 1'b1, data: 8'h17, last: 1'b1, addr: 8'h08, done: 1'b0};
    stalls[4] = '{ready: 1'b0, valid: 1'b1, data: 8'h17, last: 1'b1, addr: 8'h08, done: 1'b0};
    stalls[5] = '{ready: 1'b1, valid: 1'b0, data: 8'h17, last: 1'b0, addr: 8'h08, done: 1'b1};
    stalls[6] = '{ready: 1'b1, valid: 1'b0, data: 8'h17, last: 1'b0, addr: 8'h08, done: 1'b0};

    s_if.ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_addr", rom_addr, 0);
    chk("rst_valid", s_if.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Asynchronous reset in the middle of a transfer, away from any clock edge.
    base_addr = 8'h00;
    length    = 9'd4;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", s_if.valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_addr", rom_addr, 0);
    chk("arst_data", s_if.data, 0);
    chk("arst_valid", s_if.valid, 0);
    chk("arst_last", s_if.last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_done", done, 0);

    foreach (xfers[n]) run_xfer(xfers[n], 1'b0);

    // Back-pressure with ready pattern 1,0,0,1,0,1.
    s_if.ready = 1'b1;
    base_addr  = 8'h05;
    length     = 9'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stall_first_valid", s_if.valid, 1);
    chk("stall_first_data", s_if.data, 8'h15);
    chk("stall_first_addr", rom_addr, 8'h06);
    foreach (stalls[n]) begin
      s_if.ready = stalls[n].ready;
      tick();
      chk("stall_valid", s_if.valid, stalls[n].valid);
      if (stalls[n].valid) chk("stall_data", s_if.data, stalls[n].data);
      chk("stall_last", s_if.last, stalls[n].last);
      chk("stall_addr", rom_addr, stalls[n].addr);
      chk("stall_done", done, stalls[n].done);
    end
    chk("stall_busy", busy, 0);

    // Zero-length start: done only.
    s_if.ready = 1'b1;
    base_addr  = 8'h10;
    length     = 9'd0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_valid", s_if.valid, 0);
    tick();
    chk("zero_done_clear", done, 0);
    chk("zero_valid2", s_if.valid, 0);

    // Start held high during a transfer must not disturb it.
    run_xfer('{base: 8'h00, len: 9'd2, first_data: 8'h10, last_data: 8'h11}, 1'b1);

    // Abort after the third accepted beat.
    s_if.ready = 1'b1;
    base_addr  = 8'h20;
    length     = 9'd8;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_pre_data", s_if.data, 8'h32);
    tick();
    chk("abort_pre_data2", s_if.data, 8'h33);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", s_if.valid, 0);
    chk("abort_last", s_if.last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr_hold", rom_addr, 8'h24);
    tick();
    chk("abort_done2", done, 0);
    chk("abort_valid2", s_if.valid, 0);

    // Start coincident with abort while idle is honored.
    base_addr = 8'h30;
    length    = 9'd1;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("restart_busy", busy, 1);
    tick();
    chk("restart_valid", s_if.valid, 1);
    chk("restart_data", s_if.data, 8'h40);
    chk("restart_last", s_if.last, 1);
    tick();
    chk("restart_done", done, 1);
    chk("restart_novalid", s_if.valid, 0);
    tick();
    chk("restart_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
